flit_demux_n: RTL

Parametrised, flow-controlled 1-to-N flit de-multiplexer for the router datapath. It steers flits from one input channel to one of `NUM_OUT` output channels using a one-hot select. The route is locked on the head flit and held until the tail flit. Each output has its own registered valid/ready stage, so back-pressure on one output never corrupts another. It replaces the purely combinational 4-way demux wherever wormhole packets cross a clock edge between the input buffer and the crossbar.

---
 rtl/noc_pkg.sv | 22 ++
 rtl/demux_out_slot.sv | 34 +++
 rtl/flit_demux_n.sv | 116 +++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared definitions for the router datapath blocks: the wormhole demux
// state encoding and the one-hot legality check used on select vectors.
package noc_pkg;

   // Widest select vector the legality check is able to examine.
   localparam int MAX_OUT = 64;

   // Wormhole route state: IDLE waits for a head, LOCKED follows route_q.
   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } demux_state_t;

   // True when exactly one bit of the (zero-extended) select vector is set.
   // Clearing the lowest set bit leaves zero only for a single set bit.
   function automatic logic is_onehot(input logic [MAX_OUT-1:0] vec);
      logic [MAX_OUT-1:0] lowest_cleared;
      lowest_cleared = vec & (vec - MAX_OUT'(1));
      return (vec != '0) && (lowest_cleared == '0);
   endfunction

endpackage : noc_pkg

// File: rtl/demux_out_slot.sv
// One-entry output register for a single demux port. Holds one flit with
// its valid flag; data reads as zero whenever the slot is empty so that
// idle ports never show stale payload downstream.
module demux_out_slot #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  ready,
   output logic [DATA_WIDTH-1:0] data,
   output logic                  valid,
   output logic                  free
);

   // The slot can take a new flit when it is empty or is draining this cycle.
   assign free = !valid || ready;

   // Load on write (even while draining), otherwise clear to zero on drain.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (wr_en) begin
         valid <= 1'b1;
         data  <= wr_data;
      end else if (valid && ready) begin
         valid <= 1'b0;
         data  <= '0;
      end
   end

endmodule : demux_out_slot

// File: rtl/flit_demux_n.sv
// Flow-controlled 1-to-N wormhole flit demultiplexer. The output port is
// chosen by a one-hot select on the head flit, locked into route_q, and
// held for all following flits up to and including the tail. Each port has
// its own registered slot, so a stall on one port only throttles the input
// while that port is the current target.
module flit_demux_n
   import noc_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_OUT    = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_OUT-1:0]            sel,
   input  logic [DATA_WIDTH-1:0]         data_i,
   input  logic                          valid_i,
   input  logic                          head_i,
   input  logic                          tail_i,
   output logic                          ready_o,
   output logic [NUM_OUT*DATA_WIDTH-1:0] data_o,
   output logic [NUM_OUT-1:0]            valid_o,
   input  logic [NUM_OUT-1:0]            ready_i,
   output logic                          err_o
);

   demux_state_t       state;
   logic [NUM_OUT-1:0] route_q;
   logic [MAX_OUT-1:0] sel_ext;
   logic               legal_head;
   logic               route_ok;
   logic               accept;
   logic               discard;
   logic [NUM_OUT-1:0] target;
   logic [NUM_OUT-1:0] slot_free;
   logic [NUM_OUT-1:0] wr_en;

   // Zero-extend the select so the shared legality check sees a fixed width.
   always_comb begin
      sel_ext                = '0;
      sel_ext[NUM_OUT-1:0]   = sel;
   end

   // Classify the offered flit and pick the port it would be written to.
   // In LOCKED every flit follows route_q regardless of head_i or sel; in
   // IDLE only a head with a single select bit has a destination.
   always_comb begin
      legal_head = head_i && is_onehot(sel_ext);
      if (state == LOCKED) begin
         route_ok = 1'b1;
         target   = route_q;
      end else begin
         route_ok = legal_head;
         target   = legal_head ? sel : '0;
      end
   end

   // Input accept: a routable flit waits for its own slot; a flit that will
   // be discarded is always taken so that the input never deadlocks on it.
   always_comb begin
      if (route_ok) begin
         ready_o = |(target & slot_free);
      end else begin
         ready_o = 1'b1;
      end
   end

   assign accept  = valid_i && ready_o;
   assign discard = accept && !route_ok;
   assign wr_en   = (accept && route_ok) ? target : '0;

   // Route state machine, route register and registered error pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         route_q <= '0;
         err_o   <= 1'b0;
      end else begin
         err_o <= discard;
         case (state)
            IDLE: begin
               if (accept && legal_head) begin
                  route_q <= sel;
                  if (!tail_i) begin
                     state <= LOCKED;
                  end
               end
            end
            LOCKED: begin
               if (accept && tail_i) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // One registered output slot per port, packed onto the flat output bus.
   for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
      demux_out_slot #(
         .DATA_WIDTH(DATA_WIDTH)
      ) u_slot (
         .clk    (clk),
         .rst    (rst),
         .wr_en  (wr_en[k]),
         .wr_data(data_i),
         .ready  (ready_i[k]),
         .data   (data_o[k*DATA_WIDTH +: DATA_WIDTH]),
         .valid  (valid_o[k]),
         .free   (slot_free[k])
      );
   end

endmodule : flit_demux_n
